display_scan_mux: RTL and testbench

Time-multiplexing scan controller for the board's multi-digit 7-segment display. It holds a snapshot of NUM_DIGITS 3-bit values and steps through them at a prescaled rate. For each slot it presents one 3-bit code to the downstream 3-bit-to-7-segment decoder and drives the matching active-low digit enable. It sits between the processor's observable state (register/result values) and the segment decoder.

---
 rtl/display_pkg.sv | 24 ++
 rtl/display_scan_mux_if.sv | 28 ++
 rtl/display_tick_gen.sv | 37 +++
 rtl/display_scan_mux.sv | 119 +++++++++++
 tb/tb_display_scan_mux.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================
// display_pkg : shared constants for the 7-segment display path
// Rev 1.0
// ============================================================
package display_pkg;

    localparam int DIGIT_W    = 3;
    localparam int MAX_DIGITS = 8;

    // Active-low "all digits off" pattern; caller truncates to its digit count.
    function automatic logic [MAX_DIGITS-1:0] all_off(input int num_digits);
        logic [MAX_DIGITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < num_digits) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_mux_if.sv
`default_nettype none
// ============================================================
// display_scan_mux_if : snapshot load / scan output bundle
// Rev 1.0
// ============================================================
interface display_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [display_pkg::DIGIT_W*NUM_DIGITS-1:0] values;
    logic                                       load;
    logic [NUM_DIGITS-1:0]                      blank_mask;
    logic                                       load_ack;
    logic [display_pkg::DIGIT_W-1:0]            digit_code;
    logic                                       digit_valid;
    logic [NUM_DIGITS-1:0]                      digit_en;
    logic                                       frame_done;

    modport master (
        output values, load, blank_mask,
        input  load_ack, digit_code, digit_valid, digit_en, frame_done
    );

    modport slave (
        input  values, load, blank_mask,
        output load_ack, digit_code, digit_valid, digit_en, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/display_tick_gen.sv
`default_nettype none
// ============================================================
// display_tick_gen : free-running prescaler, one-cycle wrap tick
// Rev 1.0
// ============================================================
module display_tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      tick
);
    localparam int             CW     = $clog2(PRESCALE);
    localparam logic [CW-1:0]  c_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count_q;
    logic [CW-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q + CW'(1);
        if (r_count_q == c_LAST) begin
            w_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign tick = (r_count_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================
// display_scan_mux : time-multiplexed multi-digit display scanner
// Rev 1.0
// ============================================================
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    display_scan_mux_if.slave  bus
);
    localparam int                     IW         = $clog2(NUM_DIGITS);
    localparam int                     DW         = $clog2(DEAD_CYCLES + 1);
    localparam int                     SW         = DIGIT_W * NUM_DIGITS;
    localparam logic [IW-1:0]          c_LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0]          c_DEAD     = DW'(DEAD_CYCLES);
    localparam logic [NUM_DIGITS-1:0]  c_ALL_OFF  = NUM_DIGITS'(all_off(NUM_DIGITS));

    logic                   w_tick;
    logic [IW-1:0]          r_index_q, w_index_d;
    logic [DW-1:0]          r_dead_q, w_dead_d;
    logic [SW-1:0]          r_snap_q, w_snap_d;
    logic [DIGIT_W-1:0]     r_code_q, w_code_d;
    logic                   r_valid_q, w_valid_d;
    logic [NUM_DIGITS-1:0]  r_en_q, w_en_d;
    logic                   r_ack_q, w_ack_d;
    logic                   r_frame_q, w_frame_d;

    logic [IW-1:0]          w_next_idx;
    logic [SW-1:0]          w_src;
    logic [DIGIT_W-1:0]     w_field;
    logic                   w_blank;
    logic [NUM_DIGITS-1:0]  w_sel_n;

    display_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // A load on the switch edge must be visible in the newly selected digit.
    always_comb begin
        w_next_idx = (r_index_q == c_LAST_IDX) ? '0 : r_index_q + IW'(1);
        w_src      = bus.load ? bus.values : r_snap_q;
        w_field    = '0;
        w_blank    = 1'b0;
        w_sel_n    = c_ALL_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_next_idx == IW'(i)) begin
                w_field = w_src[i*DIGIT_W +: DIGIT_W];
                w_blank = bus.blank_mask[i];
            end
            if (r_index_q == IW'(i)) begin
                w_sel_n[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_index_d = r_index_q;
        w_dead_d  = r_dead_q;
        w_snap_d  = bus.load ? bus.values : r_snap_q;
        w_code_d  = r_code_q;
        w_valid_d = r_valid_q;
        w_en_d    = r_en_q;
        w_ack_d   = bus.load;
        w_frame_d = 1'b0;
        if (w_tick) begin
            w_index_d = w_next_idx;
            w_dead_d  = c_DEAD;
            w_en_d    = c_ALL_OFF;
            w_code_d  = w_blank ? '0 : w_field;
            w_valid_d = ~w_blank;
            w_frame_d = (w_next_idx == '0);
        end else if (r_dead_q != '0) begin
            w_dead_d = r_dead_q - DW'(1);
            if (r_dead_q == DW'(1) && r_valid_q) begin
                w_en_d = w_sel_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index_q <= c_LAST_IDX;
            r_dead_q  <= '0;
            r_snap_q  <= '0;
            r_code_q  <= '0;
            r_valid_q <= 1'b0;
            r_en_q    <= c_ALL_OFF;
            r_ack_q   <= 1'b0;
            r_frame_q <= 1'b0;
        end else begin
            r_index_q <= w_index_d;
            r_dead_q  <= w_dead_d;
            r_snap_q  <= w_snap_d;
            r_code_q  <= w_code_d;
            r_valid_q <= w_valid_d;
            r_en_q    <= w_en_d;
            r_ack_q   <= w_ack_d;
            r_frame_q <= w_frame_d;
        end
    end

    assign bus.load_ack    = r_ack_q;
    assign bus.digit_code  = r_code_q;
    assign bus.digit_valid = r_valid_q;
    assign bus.digit_en    = r_en_q;
    assign bus.frame_done  = r_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================
// tb_display_scan_mux : self-checking bench for display_scan_mux
// Rev 1.0
// ============================================================
module tb_display_scan_mux;
    localparam int N = 4;
    localparam int P = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scan_mux_if #(.NUM_DIGITS(N)) bus ();

    display_scan_mux #(
        .NUM_DIGITS  (N),
        .PRESCALE    (P),
        .DEAD_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset plus what the display currently shows.
    int         edge_n;
    int         m_idx;
    logic [11:0] m_snap;
    logic [2:0] m_code;
    logic       m_valid;
    logic       m_ack;
    logic       m_fd;

    function automatic logic [3:0] m_en();
        if (edge_n < P || !m_valid) return 4'hF;
        if ((edge_n % P) >= D) return ~(4'b0001 << m_idx);
        return 4'hF;
    endfunction

    task automatic model_reset();
        edge_n  = 0;
        m_idx   = N - 1;
        m_snap  = '0;
        m_code  = '0;
        m_valid = 1'b0;
        m_ack   = 1'b0;
        m_fd    = 1'b0;
    endtask

    task automatic tick();
        logic [11:0] src;
        @(posedge clk);
        edge_n++;
        m_ack = bus.load;
        m_fd  = 1'b0;
        if (edge_n % P == 0) begin
            m_idx = (edge_n / P - 1) % N;
            src   = bus.load ? bus.values : m_snap;
            if (bus.blank_mask[m_idx]) begin
                m_code  = '0;
                m_valid = 1'b0;
            end else begin
                m_code  = src[3*m_idx +: 3];
                m_valid = 1'b1;
            end
            m_fd = (m_idx == 0);
        end
        if (bus.load) m_snap = bus.values;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.load = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic start_with(input logic [11:0] v);
        do_reset();
        bus.values = v;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic test_reset();
        bus.values     = 12'o7777;
        bus.blank_mask = '0;
        do_reset();
        checks++;
        if (bus.digit_code !== 3'd0) begin errors++; $display("FAIL rst_code: got %0d want 0", bus.digit_code); end
        checks++;
        if (bus.digit_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.digit_valid); end
        checks++;
        if (bus.digit_en !== 4'hF) begin errors++; $display("FAIL rst_en: got %b want 1111", bus.digit_en); end
        checks++;
        if (bus.load_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL rst_pulses: got ack=%0b fd=%0b want 0 0", bus.load_ack, bus.frame_done);
        end
    endtask

    task automatic test_scan();
        start_with(12'o7531);
        checks++;
        if (bus.load_ack !== 1'b1) begin errors++; $display("FAIL scan_ack: got %0b want 1", bus.load_ack); end
        for (int e = 2; e <= 41; e++) begin
            tick();
            if (e == 2) begin
                checks++;
                if (bus.load_ack !== 1'b0) begin errors++; $display("FAIL scan_ack_drop: got %0b want 0", bus.load_ack); end
            end
            if (e == 7 || e == 9) begin
                checks++;
                if (bus.digit_en !== 4'hF) begin errors++; $display("FAIL scan_en_e%0d: got %b want 1111", e, bus.digit_en); end
            end
            if (e == 8) begin
                checks++;
                if (bus.digit_code !== 3'd1 || bus.digit_valid !== 1'b1 || bus.frame_done !== 1'b1) begin
                    errors++; $display("FAIL scan_e8: got code=%0d valid=%0b fd=%0b want 1 1 1", bus.digit_code, bus.digit_valid, bus.frame_done);
                end
            end
            if (e == 10) begin
                checks++;
                if (bus.digit_en !== 4'b1110) begin errors++; $display("FAIL scan_en_e10: got %b want 1110", bus.digit_en); end
            end
            if (e == 16) begin
                checks++;
                if (bus.digit_code !== 3'd3 || bus.digit_en !== 4'hF || bus.frame_done !== 1'b0) begin
                    errors++; $display("FAIL scan_e16: got code=%0d en=%b fd=%0b want 3 1111 0", bus.digit_code, bus.digit_en, bus.frame_done);
                end
            end
            if (e == 18) begin
                checks++;
                if (bus.digit_en !== 4'b1101) begin errors++; $display("FAIL scan_en_e18: got %b want 1101", bus.digit_en); end
            end
            if (e == 26 || e == 34) begin
                checks++;
                if (bus.digit_code !== ((e == 26) ? 3'd5 : 3'd7) || bus.digit_en !== ((e == 26) ? 4'b1011 : 4'b0111)) begin
                    errors++; $display("FAIL scan_e%0d: got code=%0d en=%b", e, bus.digit_code, bus.digit_en);
                end
            end
            if (e == 40 || e == 41) begin
                checks++;
                if (bus.frame_done !== (e == 40)) begin errors++; $display("FAIL scan_fd_e%0d: got %0b want %0b", e, bus.frame_done, (e == 40)); end
            end
        end
    endtask

    task automatic test_blank();
        logic [2:0] codes [4];
        logic [3:0] ens   [4];
        int s;
        codes = '{3'd1, 3'd3, 3'd0, 3'd7};
        ens   = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
        bus.blank_mask = 4'b0100;
        start_with(12'o7531);
        for (int e = 2; e <= 40; e++) begin
            tick();
            if (e >= 8) begin
                s = (e / P - 1) % N;
                checks++;
                if (bus.digit_code !== codes[s] || bus.digit_valid !== (s != 2)) begin
                    errors++; $display("FAIL blank_code_e%0d: got code=%0d valid=%0b want %0d %0b", e, bus.digit_code, bus.digit_valid, codes[s], (s != 2));
                end
                checks++;
                if (bus.digit_en !== (((e % P) >= D) ? ens[s] : 4'hF)) begin
                    errors++; $display("FAIL blank_en_e%0d: got %b want %b", e, bus.digit_en, (((e % P) >= D) ? ens[s] : 4'hF));
                end
            end
        end
        bus.blank_mask = '0;
    endtask

    task automatic test_load_mid();
        start_with(12'o7531);
        for (int e = 2; e <= 11; e++) tick();
        bus.values = 12'o0000;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
        for (int e = 12; e <= 15; e++) begin
            if (e > 12) tick();
            checks++;
            if (bus.digit_code !== 3'd1) begin errors++; $display("FAIL ldmid_hold_e%0d: got %0d want 1", e, bus.digit_code); end
        end
        tick();
        checks++;
        if (bus.digit_code !== 3'd0 || bus.digit_valid !== 1'b1) begin
            errors++; $display("FAIL ldmid_e16: got code=%0d valid=%0b want 0 1", bus.digit_code, bus.digit_valid);
        end
        tick();
        tick();
        checks++;
        if (bus.digit_en !== 4'b1101) begin errors++; $display("FAIL ldmid_en_e18: got %b want 1101", bus.digit_en); end
    endtask

    task automatic test_load_switch();
        start_with(12'o7531);
        for (int e = 2; e <= 15; e++) tick();
        bus.values = 12'o6666;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
        checks++;
        if (bus.digit_code !== 3'd6 || bus.digit_en !== 4'hF) begin
            errors++; $display("FAIL ldsw_e16: got code=%0d en=%b want 6 1111", bus.digit_code, bus.digit_en);
        end
        for (int e = 17; e <= 24; e++) tick();
        checks++;
        if (bus.digit_code !== 3'd6) begin errors++; $display("FAIL ldsw_e24: got %0d want 6", bus.digit_code); end
    endtask

    task automatic test_reset_mid();
        start_with(12'o7531);
        for (int e = 2; e <= 17; e++) tick();
        checks++;
        if (bus.digit_code !== 3'd3 || bus.digit_en !== 4'hF) begin
            errors++; $display("FAIL rmid_pre: got code=%0d en=%b want 3 1111", bus.digit_code, bus.digit_en);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.digit_code !== 3'd0 || bus.digit_valid !== 1'b0 || bus.digit_en !== 4'hF || bus.frame_done !== 1'b0 || bus.load_ack !== 1'b0) begin
            errors++; $display("FAIL rmid_async: got code=%0d valid=%0b en=%b fd=%0b ack=%0b want 0 0 1111 0 0",
                               bus.digit_code, bus.digit_valid, bus.digit_en, bus.frame_done, bus.load_ack);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (bus.frame_done !== 1'b0 || bus.digit_en !== 4'hF || bus.digit_valid !== 1'b0) begin
                errors++; $display("FAIL rmid_idle_e%0d: got fd=%0b en=%b valid=%0b want 0 1111 0", e, bus.frame_done, bus.digit_en, bus.digit_valid);
            end
        end
        tick();
        checks++;
        if (bus.frame_done !== 1'b1 || bus.digit_code !== 3'd0 || bus.digit_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_e8: got fd=%0b code=%0d valid=%0b want 1 0 1", bus.frame_done, bus.digit_code, bus.digit_valid);
        end
        tick();
        tick();
        checks++;
        if (bus.digit_en !== 4'b1110) begin errors++; $display("FAIL rmid_en_e10: got %b want 1110", bus.digit_en); end
        for (int e = 11; e <= 16; e++) tick();
        checks++;
        if (bus.digit_code !== 3'd0) begin errors++; $display("FAIL rmid_snap_e16: got %0d want 0", bus.digit_code); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.load       = ($urandom_range(0, 3) == 0);
            bus.values     = 12'($urandom);
            bus.blank_mask = 4'($urandom);
            tick();
            checks++;
            if (bus.digit_code !== m_code || bus.digit_valid !== m_valid) begin
                errors++; $display("FAIL rand_code_c%0d: got code=%0d valid=%0b want %0d %0b", c, bus.digit_code, bus.digit_valid, m_code, m_valid);
            end
            checks++;
            if (bus.digit_en !== m_en()) begin
                errors++; $display("FAIL rand_en_c%0d: got %b want %b", c, bus.digit_en, m_en());
            end
            checks++;
            if (bus.load_ack !== m_ack || bus.frame_done !== m_fd) begin
                errors++; $display("FAIL rand_pulse_c%0d: got ack=%0b fd=%0b want %0b %0b", c, bus.load_ack, bus.frame_done, m_ack, m_fd);
            end
        end
        bus.load       = 1'b0;
        bus.blank_mask = '0;
    endtask

    initial begin
        bus.values     = '0;
        bus.load       = 1'b0;
        bus.blank_mask = '0;
        model_reset();
        test_reset();
        test_scan();
        test_blank();
        test_load_mid();
        test_load_switch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
